// File: rtl/uart_rx_pkg.sv
// Shared types for the UART-to-AXI-Stream receiver.
// UART_RX_PARITY_EN adds the PARITY state (8E1 frames).
package uart_rx_pkg;

  localparam int DATA_BITS = 8;

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } rx_state_e;
`else
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_STOP   = 3'd4
  } rx_state_e;
`endif

  typedef struct packed {
    logic                 last;
    logic [DATA_BITS-1:0] data;
  } rx_entry_t;

  // Even parity: a set result means the data bits plus parity bit have odd weight.
  function automatic logic even_parity_bad(input logic [DATA_BITS-1:0] data,
                                           input logic                 par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous FIFO of received entries; a push is accepted while full if a
// pop happens in the same cycle.
module uart_rx_fifo
  import uart_rx_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      push_i,
  input  rx_entry_t wdata_i,
  input  logic      pop_i,
  output rx_entry_t rdata_o,
  output logic      full_o,
  output logic      empty_o
);

  localparam int AW = $clog2(FIFO_DEPTH);

  rx_entry_t       mem_q [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_q;
  logic [AW-1:0]   rd_ptr_q;
  logic [AW:0]     count_q;
  logic            push_ok_s;
  logic            pop_ok_s;

  assign full_o    = (count_q == (AW+1)'(FIFO_DEPTH));
  assign empty_o   = (count_q == {(AW+1){1'b0}});
  assign pop_ok_s  = pop_i && !empty_o;
  assign push_ok_s = push_i && (!full_o || pop_ok_s);
  assign rdata_o   = mem_q[rd_ptr_q];

  // Storage, pointers and occupancy; pointers wrap naturally (power-of-two depth).
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok_s) begin
        mem_q[wr_ptr_q] <= wdata_i;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_axis.sv
// UART receiver (8N1, or 8E1 with UART_RX_PARITY_EN) feeding an AXI-Stream
// byte stream through a small FIFO.
module uart_rx_axis
  import uart_rx_pkg::*;
#(
  parameter int         CLKS_PER_BIT = 434,
  parameter int         FIFO_DEPTH   = 4,
  parameter logic [7:0] EOP_BYTE     = 8'h0A
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       uart_rx,
  output logic [7:0] m_axis_data,
  output logic       m_axis_valid,
  output logic       m_axis_last,
  input  logic       m_axis_ready,
`ifdef UART_RX_PARITY_EN
  output logic       parity_err,
`endif
  output logic       frame_err,
  output logic       overrun
);

  localparam int HALF = CLKS_PER_BIT / 2;
  localparam int CW   = $clog2(CLKS_PER_BIT);

  rx_state_e             state_q, state_d;
  logic [CW-1:0]         baud_q, baud_d;
  logic [2:0]            bit_q, bit_d;
  logic [DATA_BITS-1:0]  shift_q, shift_d;
  logic                  sync1_q, sync2_q, prev_q;
  logic                  frame_err_q, frame_err_d;
  logic                  overrun_q, overrun_d;
  logic                  tick_s, push_s, pop_s, full_s, empty_s;
  rx_entry_t             wentry_s, rentry_s;
`ifdef UART_RX_PARITY_EN
  logic                  par_bad_q, par_bad_d;
  logic                  parity_err_q, parity_err_d;
  assign parity_err = parity_err_q;
`endif

  assign tick_s        = (baud_q == CW'(CLKS_PER_BIT - 1));
  assign pop_s         = m_axis_valid && m_axis_ready;
  assign wentry_s.last = (shift_q == EOP_BYTE);
  assign wentry_s.data = shift_q;

  // Synchronizer, edge history and FSM registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      prev_q      <= 1'b1;
      state_q     <= ST_IDLE;
      baud_q      <= '0;
      bit_q       <= 3'd0;
      shift_q     <= '0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_q    <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      sync1_q     <= uart_rx;
      sync2_q     <= sync1_q;
      prev_q      <= sync2_q;
      state_q     <= state_d;
      baud_q      <= baud_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
`ifdef UART_RX_PARITY_EN
      par_bad_q    <= par_bad_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  // Next-state logic; the baud counter restarts at every sample point.
  always_comb begin
    state_d     = state_q;
    baud_d      = baud_q + CW'(1);
    bit_d       = bit_q;
    shift_d     = shift_q;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;
    push_s      = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_d    = par_bad_q;
    parity_err_d = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        baud_d = '0;
        // Only a falling edge starts a frame, so a line stuck low stays idle.
        if (prev_q && !sync2_q) begin
          state_d = ST_START;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_START: begin
        if (baud_q == CW'(HALF - 1)) begin
          baud_d  = '0;
          bit_d   = 3'd0;
          state_d = sync2_q ? ST_IDLE : ST_DATA;
        end else begin
          state_d = ST_START;
        end
      end
      ST_DATA: begin
        if (tick_s) begin
          baud_d  = '0;
          shift_d = {sync2_q, shift_q[DATA_BITS-1:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end else begin
            state_d = ST_DATA;
          end
        end else begin
          state_d = ST_DATA;
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (tick_s) begin
          baud_d    = '0;
          par_bad_d = even_parity_bad(shift_q, sync2_q);
          state_d   = ST_STOP;
        end else begin
          state_d = ST_PARITY;
        end
      end
`endif
      ST_STOP: begin
        if (tick_s) begin
          baud_d  = '0;
          state_d = ST_IDLE;
          if (!sync2_q) begin
            frame_err_d = 1'b1;
`ifdef UART_RX_PARITY_EN
          end else if (par_bad_q) begin
            parity_err_d = 1'b1;
`endif
          end else if (full_s && !pop_s) begin
            overrun_d = 1'b1;
          end else begin
            push_s = 1'b1;
          end
        end else begin
          state_d = ST_STOP;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  uart_rx_fifo #(
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push_s),
    .wdata_i (wentry_s),
    .pop_i   (pop_s),
    .rdata_o (rentry_s),
    .full_o  (full_s),
    .empty_o (empty_s)
  );

  assign m_axis_valid = !empty_s;
  assign m_axis_data  = rentry_s.data;
  assign m_axis_last  = rentry_s.last;
  assign frame_err    = frame_err_q;
  assign overrun      = overrun_q;

endmodule
